// File: rtl/memory_stream_writer.sv
// memory_stream_writer
//
// Write-side loader for a coreir_mem style memory. After a START pulse the
// block takes up to `depth` words from a valid/ready stream and writes them
// to consecutive addresses starting at 0. It then pulses DONE for one cycle
// so that readers know the contents are ready.
//
// Ports
//   CLK         clock; all state changes on the rising edge
//   ASYNCRESET  asynchronous active-high reset
//   START       begin a fill; sampled only in IDLE
//   COUNT       number of words to write; sampled together with START
//   I_VALID     stream word valid
//   I_DATA      stream word
//   I_READY     the block accepts I_DATA this cycle (decoded from state)
//   WADDR       memory write address (registered)
//   WDATA       memory write data (registered)
//   WEN         memory write enable (registered)
//   BUSY        a fill is in progress (registered)
//   DONE        one-cycle completion pulse (registered)
//   ERR         sticky: COUNT exceeded depth on the last START (registered)

module memory_stream_writer #(
    parameter int   width = 5,
    parameter int   depth = 4,
    localparam int  AW    = $clog2(depth)
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             START,
    input  logic [AW:0]      COUNT,
    input  logic             I_VALID,
    input  logic [width-1:0] I_DATA,
    output logic             I_READY,
    output logic [AW-1:0]    WADDR,
    output logic [width-1:0] WDATA,
    output logic             WEN,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_t;

    // COUNT is one bit wider than the address so that depth itself fits.
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(depth);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    state_t             state_q, state_d;
    logic [AW:0]        n_q, n_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [AW-1:0]      waddr_q, waddr_d;
    logic [width-1:0]   wdata_q, wdata_d;
    logic               wen_q, wen_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // Next-state and next-output logic. WEN and DONE are pulses and default
    // to 0 every cycle; WADDR/WDATA hold unless a word is accepted. The
    // address counter wraps to 0 after the last word of a full-depth fill,
    // which is harmless because the fill ends on that same word.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (START) begin
                    n_d    = (COUNT > DEPTH_W) ? DEPTH_W : COUNT;
                    cnt_d  = '0;
                    addr_d = '0;
                    err_d  = (COUNT > DEPTH_W);
                    if (COUNT == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                        busy_d  = 1'b1;
                    end
                end
            end

            ST_FILL: begin
                // I_READY is high throughout FILL, so I_VALID alone marks a handshake.
                if (I_VALID) begin
                    wen_d   = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = I_DATA;
                    addr_d  = addr_q + ADDR_ONE;
                    cnt_d   = cnt_q + CNT_ONE;
                    if ((cnt_q + CNT_ONE) == n_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears every output and counter.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign I_READY = (state_q == ST_FILL);
    assign WADDR   = waddr_q;
    assign WDATA   = wdata_q;
    assign WEN     = wen_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_memory_stream_writer.sv
// tb_memory_stream_writer
//
// Drives memory_stream_writer (width=5, depth=4) with directed and random
// fills. A small array stands in for a coreir_mem with combinational read
// (raddr/rdata). Expected writes, DONE timing and memory contents come from
// a word-level reference: the first N accepted words land at addresses
// 0..N-1, each write appears the cycle after its handshake, and DONE
// coincides with the last write.

module tb_memory_stream_writer;

    logic       CLK = 1'b0;
    logic       ASYNCRESET;
    logic       START;
    logic [2:0] COUNT;
    logic       I_VALID;
    logic [4:0] I_DATA;
    logic       I_READY;
    logic [1:0] WADDR;
    logic [4:0] WDATA;
    logic       WEN;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    // Memory stand-in: synchronous write, combinational read.
    logic [4:0] mem [4];
    logic [1:0] raddr;
    logic [4:0] rdata;

    // Reference memory contents and which addresses are known.
    logic [4:0] ref_mem [4];
    bit         ref_known [4];
    logic [1:0] last_waddr;
    logic [4:0] last_wdata;

    // Optional directed data words and valid pattern for the next fill.
    logic [4:0] data_q [$];
    bit         valid_q [$];

    int checks;
    int errors;

    memory_stream_writer #(.width(5), .depth(4)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .START      (START),
        .COUNT      (COUNT),
        .I_VALID    (I_VALID),
        .I_DATA     (I_DATA),
        .I_READY    (I_READY),
        .WADDR      (WADDR),
        .WDATA      (WDATA),
        .WEN        (WEN),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    // Free-running 10-unit clock.
    always #5 CLK = ~CLK;

    // The memory commits a write on the rising edge while WEN is high.
    always @(posedge CLK) begin
        if (WEN) mem[WADDR] <= WDATA;
    end

    assign rdata = mem[raddr];

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let the rising edge happen, and return on
    // the following falling edge where outputs are sampled.
    task automatic applyStimulus(input logic start, input logic [2:0] count,
                                 input logic valid, input logic [4:0] data);
        START   = start;
        COUNT   = count;
        I_VALID = valid;
        I_DATA  = data;
        @(posedge CLK);
        @(negedge CLK);
        START   = 1'b0;
        I_VALID = 1'b0;
    endtask

    // Read back every address the reference knows and compare.
    task automatic checkMemory();
        for (int i = 0; i < 4; i++) begin
            if (ref_known[i]) begin
                raddr = 2'(i);
                #1;
                checkOutput($sformatf("readback%0d", i), 32'(rdata), 32'(ref_mem[i]));
            end
        end
    endtask

    // One complete fill. extra_start holds START high through FILL and DONE
    // (with COUNT=1) to show it is ignored there; settle adds an idle cycle.
    task automatic runFill(input logic [2:0] count, input int valid_pct,
                           input bit extra_start, input bit settle);
        int         n;
        int         accepted;
        int         cycles;
        bit         v;
        bit         exp_err;
        logic [4:0] d;
        n        = (count > 3'd4) ? 4 : int'(count);
        exp_err  = (count > 3'd4);
        accepted = 0;
        cycles   = 0;
        checkOutput("idleReady", 32'(I_READY), 0);
        checkOutput("idleBusy", 32'(BUSY), 0);
        applyStimulus(1'b1, count, 1'($urandom_range(1)), 5'($urandom));
        checkOutput("errLatch", 32'(ERR), 32'(exp_err));
        checkOutput("startWen", 32'(WEN), 0);
        if (n == 0) begin
            checkOutput("zeroDone", 32'(DONE), 1);
            checkOutput("zeroBusy", 32'(BUSY), 0);
            checkOutput("zeroReady", 32'(I_READY), 0);
        end else begin
            checkOutput("fillBusy", 32'(BUSY), 1);
            checkOutput("fillDone", 32'(DONE), 0);
        end
        while (accepted < n && cycles < 100) begin
            checkOutput("fillReady", 32'(I_READY), 1);
            if (valid_q.size() > 0) v = valid_q.pop_front();
            else v = ($urandom_range(99) < valid_pct);
            if (v && data_q.size() > 0) d = data_q.pop_front();
            else d = 5'($urandom);
            applyStimulus(1'(extra_start), 3'd1, 1'(v), d);
            cycles++;
            if (v) begin
                checkOutput("wen", 32'(WEN), 1);
                checkOutput("waddr", 32'(WADDR), 32'(accepted));
                checkOutput("wdata", 32'(WDATA), 32'(d));
                ref_mem[accepted]   = d;
                ref_known[accepted] = 1'b1;
                last_waddr = 2'(accepted);
                last_wdata = d;
                accepted++;
                if (accepted == n) begin
                    checkOutput("lastDone", 32'(DONE), 1);
                    checkOutput("lastBusy", 32'(BUSY), 0);
                    checkOutput("lastReady", 32'(I_READY), 0);
                end else begin
                    checkOutput("midDone", 32'(DONE), 0);
                    checkOutput("midBusy", 32'(BUSY), 1);
                end
            end else begin
                checkOutput("gapWen", 32'(WEN), 0);
                checkOutput("gapWaddr", 32'(WADDR), 32'(last_waddr));
                checkOutput("gapWdata", 32'(WDATA), 32'(last_wdata));
                checkOutput("gapDone", 32'(DONE), 0);
            end
        end
        if (accepted < n) checkOutput("fillTimeout", 32'(accepted), 32'(n));
        // DONE cycle: any START here must not begin a new fill.
        applyStimulus(1'(extra_start), 3'd1, 1'b1, 5'($urandom));
        checkOutput("idleDone", 32'(DONE), 0);
        checkOutput("idleBusyAfter", 32'(BUSY), 0);
        checkOutput("idleReadyAfter", 32'(I_READY), 0);
        checkOutput("idleWen", 32'(WEN), 0);
        checkOutput("idleWaddr", 32'(WADDR), 32'(last_waddr));
        checkOutput("idleErr", 32'(ERR), 32'(exp_err));
        checkMemory();
        if (settle) begin
            applyStimulus(1'b0, 3'd0, 1'b1, 5'($urandom));
            checkOutput("settleBusy", 32'(BUSY), 0);
            checkOutput("settleWen", 32'(WEN), 0);
            checkOutput("settleErr", 32'(ERR), 32'(exp_err));
        end
    endtask

    // Reset lands asynchronously after the second word has been committed,
    // while the third write is still pending; that write must be lost.
    task automatic resetMidFill();
        logic [4:0] d0;
        logic [4:0] d1;
        logic [4:0] d2;
        d0 = 5'($urandom);
        d1 = 5'($urandom);
        d2 = 5'($urandom);
        applyStimulus(1'b1, 3'd4, 1'b0, 5'd0);
        applyStimulus(1'b0, 3'd0, 1'b1, d0);
        applyStimulus(1'b0, 3'd0, 1'b1, d1);
        START   = 1'b0;
        I_VALID = 1'b1;
        I_DATA  = d2;
        @(posedge CLK);
        #2 ASYNCRESET = 1'b1;
        #1;
        checkOutput("rstReady", 32'(I_READY), 0);
        checkOutput("rstWaddr", 32'(WADDR), 0);
        checkOutput("rstWdata", 32'(WDATA), 0);
        checkOutput("rstWen", 32'(WEN), 0);
        checkOutput("rstBusy", 32'(BUSY), 0);
        checkOutput("rstDone", 32'(DONE), 0);
        checkOutput("rstErr", 32'(ERR), 0);
        I_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        ref_mem[0] = d0;
        ref_mem[1] = d1;
        last_waddr = 2'd0;
        last_wdata = 5'd0;
        checkMemory();
        @(negedge CLK);
        checkOutput("postRstWen", 32'(WEN), 0);
        checkOutput("postRstBusy", 32'(BUSY), 0);
    endtask

    // Main sequence: reset checks, the directed scenarios, then random fills.
    initial begin
        checks     = 0;
        errors     = 0;
        ASYNCRESET = 1'b1;
        START      = 1'b0;
        COUNT      = 3'd0;
        I_VALID    = 1'b0;
        I_DATA     = 5'd0;
        raddr      = 2'd0;
        last_waddr = 2'd0;
        last_wdata = 5'd0;
        for (int i = 0; i < 4; i++) begin
            ref_known[i] = 1'b0;
            ref_mem[i]   = 5'd0;
        end
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("resetReady", 32'(I_READY), 0);
        checkOutput("resetWaddr", 32'(WADDR), 0);
        checkOutput("resetWdata", 32'(WDATA), 0);
        checkOutput("resetWen", 32'(WEN), 0);
        checkOutput("resetBusy", 32'(BUSY), 0);
        checkOutput("resetDone", 32'(DONE), 0);
        checkOutput("resetErr", 32'(ERR), 0);
        ASYNCRESET = 1'b0;
        @(negedge CLK);

        $display("[TB] basic fill");
        data_q = '{5'd5, 5'd0, 5'd21, 5'd11};
        runFill(3'd4, 100, 1'b0, 1'b1);

        $display("[TB] stream gaps");
        valid_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        runFill(3'd3, 0, 1'b0, 1'b1);

        $display("[TB] zero and oversize count");
        runFill(3'd0, 100, 1'b0, 1'b1);
        runFill(3'd7, 100, 1'b0, 1'b1);
        runFill(3'd1, 100, 1'b0, 1'b1);

        $display("[TB] ignored START");
        runFill(3'd3, 100, 1'b1, 1'b1);
        runFill(3'd0, 100, 1'b1, 1'b1);

        $display("[TB] reset mid-fill");
        resetMidFill();
        runFill(3'd2, 100, 1'b0, 1'b1);

        $display("[TB] back-to-back fills");
        data_q = '{5'd3, 5'd4};
        runFill(3'd2, 100, 1'b0, 1'b0);
        data_q = '{5'd9, 5'd10};
        runFill(3'd2, 100, 1'b0, 1'b1);

        $display("[TB] random fills");
        for (int k = 0; k < 25; k++) begin
            runFill(3'($urandom_range(7)), int'($urandom_range(100, 30)),
                    1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stream_writer.md
# memory_stream_writer

Sequential write-side front end for a `coreir_mem` instance: accepts a valid/ready data stream and writes it to consecutive addresses starting at 0. It is the loader counterpart to read-only memory wrappers. It fills a depth×width memory through its `wdata`/`waddr`/`wen` port, then reports completion so that downstream readers (`raddr`/`rdata`) can consume the contents. One fill operation is started per `START` pulse.

## Interface

**Parameters**
- `width`, 5: data word width in bits.
- `depth`, 4: memory depth in words; power of two, at least 2.
- `AW`, derived as `$clog2(depth)`: address width.

**Ports**
- `CLK` input 1: clock; all state changes on the rising edge.
- `ASYNCRESET` input 1: reset, asynchronous, active-high.
- `START` input 1: begin a fill; sampled only in IDLE.
- `COUNT` input AW+1: number of words to write; sampled with `START`.
- `I_VALID` input 1: stream word valid.
- `I_DATA` input width: stream word.
- `I_READY` output 1: block accepts `I_DATA` this cycle.
- `WADDR` output AW: memory write address, to `waddr`.
- `WDATA` output width: memory write data, to `wdata`.
- `WEN` output 1: memory write enable, to `wen`.
- `BUSY` output 1: high while a fill is in progress.
- `DONE` output 1: one-cycle pulse at completion.
- `ERR` output 1: sticky; `COUNT` exceeded `depth` on the last `START`.

## Operation

- **States:** IDLE, FILL, DONE.
- **IDLE**
  - `I_READY`=0 and `BUSY`=0.
  - On `START`=1, latch N = min(`COUNT`, `depth`) and clear the address counter to 0.
  - Set `ERR` = (`COUNT` > `depth`); `ERR` holds until the next `START`.
  - If N=0, go to DONE. Otherwise go to FILL.
- **FILL**
  - `I_READY`=1 and `BUSY`=1.
  - A handshake is `I_VALID` & `I_READY` at a rising edge. On each handshake:
    - register `WEN`=1, `WADDR`=current address, `WDATA`=`I_DATA`;
    - increment the address;
    - increment the accepted count.
  - On a handshake, if the accepted count reaches N, go to DONE.
  - A cycle with no handshake registers `WEN`=0.
- **DONE**
  - `DONE`=1, `BUSY`=0, `I_READY`=0.
  - `WEN` still carries the final word's write, or is 0 when N=0.
  - Unconditionally go to IDLE next cycle.
- `START` is ignored in FILL and DONE.
- Address arithmetic is AW bits wide. The address wraps to 0 only after writing `depth`-1, which happens only when N=`depth`; it is never used after wrap.
- `WADDR` and `WDATA` hold their last values when `WEN`=0.
- `I_DATA` is ignored whenever `I_READY`=0.
- **Reset, including mid-fill:**
  - all outputs go to 0;
  - state goes to IDLE;
  - counters clear.
  - Writes already committed to the memory remain; no further writes occur.

## Timing

- All outputs are registered, except `I_READY`, which decodes the current state.
- Handshake at edge t: `WEN`, `WADDR`, `WDATA` are valid in cycle t+1, and the memory commits at edge t+1.
- Throughput is one word per cycle with `I_VALID` held high. N words take N cycles in FILL plus 1 cycle in DONE.
- The last handshake at edge t gives:
  - state DONE with `DONE`=1 and the final `WEN`=1 in the same cycle;
  - IDLE in the following cycle, with a combinational read returning the final word from then on.
- Earliest next `START` is the first IDLE cycle after DONE.
- Reset values: `I_READY`=0, `WADDR`=0, `WDATA`=0, `WEN`=0, `BUSY`=0, `DONE`=0, `ERR`=0.

## Test plan

Bench instantiates `width`=5, `depth`=4, with outputs wired to a `coreir_mem` (sync_read=0).

1. **Basic fill.** `START`, `COUNT`=4, then stream 5, 0, 21, 11 with `I_VALID` always high.
   - Required: `WEN` high for 4 consecutive cycles at addresses 0–3.
   - Required: `DONE` pulses once, coincident with the address-3 write.
   - Required: readback of `raddr` 0–3 gives 5, 0, 21, 11; `ERR`=0.
2. **Stream gaps.** `COUNT`=3, with `I_VALID` toggling 1,0,0,1,0,1.
   - Required: exactly 3 writes, at addresses 0, 1, 2.
   - Required: no `WEN` in gap cycles; `DONE` one cycle after the third handshake edge.
3. **Zero and oversize count.**
   - `COUNT`=0: `DONE` the cycle after `START`, no `WEN`, `ERR`=0.
   - `COUNT`=7: exactly 4 writes, `ERR`=1 held until the next `START`.
4. **Ignored START.** Pulse `START` with `COUNT`=1 during FILL and during DONE.
   - Required: the original fill is unaffected and returns to IDLE.
   - Required: no new fill is started.
5. **Reset mid-fill.** `COUNT`=4; assert `ASYNCRESET` asynchronously after the 2nd handshake.
   - Required: all outputs 0 immediately; no further `WEN`.
   - Required: memory addresses 0–1 hold the written values.
   - Required: a subsequent `START` with `COUNT`=2 rewrites addresses 0–1.
6. **Back-to-back fills.** Run `COUNT`=2 (values 3, 4), then `START` on the first IDLE cycle with `COUNT`=2 (values 9, 10).
   - Required: the second fill overwrites addresses 0–1 with 9, 10; two `DONE` pulses.
